// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM state encoding and the
// fetch-queue entry handed to decode.
package fetch_pkg;

    // Queue entries carry a 32-bit PC and instruction; the stage's XLEN must match.
    localparam int FQ_XLEN = 32;

    typedef enum logic [2:0] {
        LOOKUP,
        REQ,
        WAIT,
        DRAIN,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [FQ_XLEN-1:0] pc;
        logic [FQ_XLEN-1:0] inst;
        logic               tlb_miss;
    } fq_entry_t;

    function automatic fq_entry_t make_entry(input logic [FQ_XLEN-1:0] pc,
                                             input logic [FQ_XLEN-1:0] inst,
                                             input logic               tlb_miss);
        fq_entry_t e;
        e.pc       = pc;
        e.inst     = inst;
        e.tlb_miss = tlb_miss;
        return e;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch-queue entries. Push is refused when full even if a
// pop happens in the same cycle; clear wins over push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  fq_entry_t push_data,
    input  logic      pop,
    input  logic      clear,
    output logic      full,
    output logic      empty,
    output fq_entry_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fq_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    // NOTE: every signal gets a default at the top of always_comb so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        do_push  = push && !full && !clear;
        do_pop   = pop && !empty && !clear;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; an entry is only observable after
    // it has been written, because empty gates the head at the consumer.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/fetch_queue_stage.sv
// Instruction-fetch front end: translates the fetch PC, requests whole lines,
// splits them into words for decode and handles redirects and iTLB misses.
module fetch_queue_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter int              LINE_BITS = 128,
    parameter int              PA_BITS   = 20,
    parameter int              FQ_DEPTH  = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic [XLEN-1:0]      tlb_va,
    input  logic [PA_BITS-1:0]   tlb_pa,
    input  logic                 tlb_miss,
    output logic                 req_valid,
    output logic [PA_BITS-1:0]   req_addr,
    input  logic                 req_ready,
    input  logic                 resp_valid,
    input  logic [LINE_BITS-1:0] resp_data,
    output logic                 inst_valid,
    output logic [XLEN-1:0]      inst,
    output logic [XLEN-1:0]      inst_pc,
    output logic                 inst_tlb_miss,
    input  logic                 inst_ready
);

    localparam int W        = LINE_BITS / XLEN;
    localparam int OFF_BITS = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS = $clog2(W);

    fetch_state_t         state_q, state_d;
    logic [XLEN-1:0]      pc_q, pc_d;
    logic [PA_BITS-1:0]   req_addr_q, req_addr_d;
    logic                 req_valid_q, req_valid_d;
    logic [LINE_BITS-1:0] line_q, line_d;
    logic                 discard_q, discard_d;
    logic                 miss_pend_q, miss_pend_d;

    logic                 fifo_push;
    fq_entry_t            fifo_data;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    fq_entry_t            fifo_head;

    logic [IDX_BITS-1:0]  word_idx;
    logic [XLEN-1:0]      cur_word;
    logic                 unused_tlb_pa_lsbs;

    assign word_idx           = pc_q[OFF_BITS-1:2];
    assign cur_word           = line_q[word_idx*XLEN +: XLEN];
    assign unused_tlb_pa_lsbs = ^tlb_pa[OFF_BITS-1:0];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        req_valid_d = req_valid_q;
        line_d      = line_q;
        discard_d   = discard_q;
        miss_pend_d = miss_pend_q;
        fifo_push   = 1'b0;
        fifo_data   = make_entry(pc_q, '0, 1'b0);

        case (state_q)
            LOOKUP: begin
                if (!fifo_full) begin
                    if (tlb_miss) begin
                        miss_pend_d = 1'b1;
                        state_d     = HALT;
                    end else begin
                        req_addr_d  = {tlb_pa[PA_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
                        req_valid_d = 1'b1;
                        state_d     = REQ;
                    end
                end
            end
            REQ: begin
                if (req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (resp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = LOOKUP;
                    end else begin
                        line_d  = resp_data;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // pc_q walks the line word by word, so after the last word it
                // already points at the next line base.
                if (!fifo_full) begin
                    fifo_push = 1'b1;
                    fifo_data = make_entry(pc_q, cur_word, 1'b0);
                    pc_d      = pc_q + XLEN'(4);
                    if (word_idx == IDX_BITS'(W - 1)) begin
                        state_d = LOOKUP;
                    end
                end
            end
            HALT: begin
                if (miss_pend_q && !fifo_full) begin
                    fifo_push   = 1'b1;
                    fifo_data   = make_entry(pc_q, '0, 1'b1);
                    miss_pend_d = 1'b0;
                end
            end
            default: state_d = LOOKUP;
        endcase

        // A redirect overrides whatever the state machine decided above; an
        // outstanding memory handshake still completes and its line is dropped.
        if (redirect_valid) begin
            fifo_push   = 1'b0;
            pc_d        = redirect_pc;
            miss_pend_d = 1'b0;
            line_d      = line_q;
            case (state_q)
                REQ: begin
                    discard_d = 1'b1;
                end
                WAIT: begin
                    if (resp_valid) begin
                        discard_d = 1'b0;
                        state_d   = LOOKUP;
                    end else begin
                        discard_d = 1'b1;
                        state_d   = WAIT;
                    end
                end
                default: begin
                    req_valid_d = 1'b0;
                    req_addr_d  = req_addr_q;
                    state_d     = LOOKUP;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= LOOKUP;
            pc_q        <= RESET_PC;
            req_addr_q  <= '0;
            req_valid_q <= 1'b0;
            line_q      <= '0;
            discard_q   <= 1'b0;
            miss_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            req_valid_q <= req_valid_d;
            line_q      <= line_d;
            discard_q   <= discard_d;
            miss_pend_q <= miss_pend_d;
        end
    end

    assign fifo_pop = inst_valid && inst_ready;

    fetch_fifo #(
        .DEPTH(FQ_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(fifo_data),
        .pop      (fifo_pop),
        .clear    (redirect_valid),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign tlb_va        = pc_q;
    assign req_valid     = req_valid_q;
    assign req_addr      = req_addr_q;
    assign inst_valid    = !fifo_empty;
    assign inst          = inst_valid ? fifo_head.inst : '0;
    assign inst_pc       = inst_valid ? fifo_head.pc : '0;
    assign inst_tlb_miss = inst_valid && fifo_head.tlb_miss;

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Directed bench for fetch_queue_stage with a granted-line memory model, an
// identity iTLB and a scoreboard of expected queue entries and request addresses.
module tb_fetch_queue_stage;
    import fetch_pkg::*;

    logic         clk;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [31:0]  tlb_va;
    logic [19:0]  tlb_pa;
    logic         tlb_miss;
    logic         req_valid;
    logic [19:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [127:0] resp_data;
    logic         inst_valid;
    logic [31:0]  inst;
    logic [31:0]  inst_pc;
    logic         inst_tlb_miss;
    logic         inst_ready;

    int           errors = 0;
    int           checks = 0;

    fq_entry_t    exp_q[$];
    logic [19:0]  exp_addr_q[$];

    logic         miss_en;
    logic [31:0]  miss_va;
    int           grants;
    int           acc_cnt;
    int           mem_delay;
    logic         stray_req;
    logic         mem_pend;
    int           mem_cnt;
    logic [19:0]  mem_addr;

    fetch_queue_stage #(
        .XLEN(32), .LINE_BITS(128), .PA_BITS(20), .FQ_DEPTH(4), .RESET_PC(32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .tlb_va        (tlb_va),
        .tlb_pa        (tlb_pa),
        .tlb_miss      (tlb_miss),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .inst_valid    (inst_valid),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .inst_tlb_miss (inst_tlb_miss),
        .inst_ready    (inst_ready)
    );

    assign tlb_pa   = tlb_va[19:0];
    assign tlb_miss = miss_en && (tlb_va == miss_va);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] p);
        return (p & 32'hFFFF_FFF0) + 32'h10 + {30'b0, p[3:2]};
    endfunction

    function automatic logic [127:0] make_line(input logic [19:0] a);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) begin
            l[k*32 +: 32] = {12'b0, a} + 32'h10 + 32'(k);
        end
        return l;
    endfunction

    task automatic push_words(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        do begin
            exp_q.push_back(make_entry(p, word_of(p), 1'b0));
            p = p + 32'd4;
        end while (p[3:0] != 4'h0);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_exp_empty(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick();
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic wait_req(input string tag);
        int n;
        n = 0;
        while (!req_valid && n < 100) begin
            tick();
            n++;
        end
        check(tag, {63'b0, req_valid}, 64'd1);
    endtask

    // Memory model: accepts only granted requests, returns one line per request.
    initial begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = '0;
        mem_pend   = 1'b0;
        mem_cnt    = 0;
        mem_addr   = '0;
        acc_cnt    = 0;
        forever begin
            @(negedge clk);
            resp_valid = 1'b0;
            if (stray_req) begin
                resp_valid = 1'b1;
                resp_data  = {4{32'hDEAD_BEEF}};
                stray_req  = 1'b0;
            end else if (mem_pend) begin
                if (mem_cnt == 0) begin
                    resp_valid = 1'b1;
                    resp_data  = make_line(mem_addr);
                    mem_pend   = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            req_ready = (grants > 0) && !mem_pend && reset;
            if (req_valid && req_ready) begin
                grants--;
                acc_cnt++;
                mem_pend = 1'b1;
                mem_cnt  = mem_delay;
                mem_addr = req_addr;
                if (exp_addr_q.size() == 0) begin
                    check("req_unexpected", {44'b0, req_addr}, 64'hFFFF_FFFF);
                end else begin
                    check("req_addr", {44'b0, req_addr}, {44'b0, exp_addr_q.pop_front()});
                end
            end
        end
    end

    // Decode-side monitor: pops the scoreboard on every handshake and checks
    // that a stalled head holds still.
    initial begin
        logic        hold_v;
        logic [63:0] held;
        fq_entry_t   e;
        hold_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (reset && inst_valid) begin
                if (hold_v) begin
                    check("head_stable", {inst_pc, inst}, held);
                end
                if (inst_ready) begin
                    hold_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        check("inst_unexpected", {inst_pc, inst}, 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        check("inst_pc", {32'b0, inst_pc}, {32'b0, e.pc});
                        check("inst", {32'b0, inst}, {32'b0, e.inst});
                        check("inst_tlb_miss", {63'b0, inst_tlb_miss}, {63'b0, e.tlb_miss});
                    end
                end else begin
                    hold_v = 1'b1;
                    held   = {inst_pc, inst};
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   target;
        logic seen;

        reset          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b1;
        miss_en        = 1'b0;
        miss_va        = '0;
        grants         = 0;
        mem_delay      = 1;
        stray_req      = 1'b0;
        repeat (2) tick();

        check("rst_tlb_va", {32'b0, tlb_va}, 64'h0);
        check("rst_req_valid", {63'b0, req_valid}, 64'd0);
        check("rst_req_addr", {44'b0, req_addr}, 64'd0);
        check("rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        check("rst_inst", {32'b0, inst}, 64'd0);
        check("rst_inst_pc", {32'b0, inst_pc}, 64'd0);
        check("rst_inst_tlb_miss", {63'b0, inst_tlb_miss}, 64'd0);

        // Line 0 after reset, including response-to-output latency.
        exp_addr_q.push_back(20'h0);
        push_words(32'h0);
        grants += 1;
        reset = 1'b1;
        n = 0;
        while (!resp_valid && n < 50) begin
            tick();
            n++;
        end
        check("t1_resp_seen", {63'b0, resp_valid}, 64'd1);
        tick();
        check("t1_r1_inst_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check("t1_r2_inst_valid", {63'b0, inst_valid}, 64'd1);
        wait_exp_empty("t1_drain");
        wait_req("t1_next_req");
        check("t1_next_addr", {44'b0, req_addr}, 64'h10);

        // Redirect while the 0x10 request is unaccepted: that line is dropped.
        exp_addr_q.push_back(20'h10);
        exp_addr_q.push_back(20'h100);
        push_words(32'h108);
        do_redirect(32'h108);
        grants += 2;
        wait_exp_empty("t2_drain");
        wait_req("t2_next_req");
        check("t2_next_addr", {44'b0, req_addr}, 64'h110);

        // Decode stall: queue fills to its depth, fetch stops, nothing lost.
        inst_ready = 1'b0;
        exp_addr_q.push_back(20'h110);
        exp_addr_q.push_back(20'h120);
        push_words(32'h110);
        push_words(32'h120);
        grants += 2;
        repeat (14) tick();
        check("t3_stall_valid", {63'b0, inst_valid}, 64'd1);
        check("t3_stall_pc", {32'b0, inst_pc}, 64'h110);
        check("t3_stall_inst", {32'b0, inst}, 64'h120);
        check("t3_stall_no_req", {63'b0, req_valid}, 64'd0);
        inst_ready = 1'b1;
        wait_exp_empty("t3_drain");
        wait_req("t3_next_req");
        check("t3_next_addr", {44'b0, req_addr}, 64'h130);

        // Redirect in WAIT with a slow response.
        mem_delay = 5;
        exp_addr_q.push_back(20'h130);
        exp_addr_q.push_back(20'h200);
        target = acc_cnt + 1;
        grants += 1;
        n = 0;
        while (acc_cnt != target && n < 50) begin
            tick();
            n++;
        end
        check("t4_accepted", 64'(acc_cnt), 64'(target));
        mem_delay = 1;
        tick();
        push_words(32'h204);
        do_redirect(32'h204);
        grants += 1;
        tick();
        check("t4_queue_empty", {63'b0, inst_valid}, 64'd0);
        wait_exp_empty("t4_drain");
        wait_req("t4_next_req");
        check("t4_next_addr", {44'b0, req_addr}, 64'h210);

        // iTLB miss at 0x2000: single marker, then fetch halts.
        miss_va = 32'h2000;
        miss_en = 1'b1;
        exp_addr_q.push_back(20'h210);
        exp_q.push_back(make_entry(32'h2000, 32'h0, 1'b1));
        do_redirect(32'h2000);
        grants += 1;
        wait_exp_empty("t5_marker");
        seen = 1'b0;
        repeat (10) begin
            tick();
            seen = seen | req_valid;
        end
        check("t5_halt_no_req", {63'b0, seen}, 64'd0);
        check("t5_halt_no_inst", {63'b0, inst_valid}, 64'd0);

        // Redirect out of HALT back onto the miss: marker two cycles after LOOKUP.
        exp_q.push_back(make_entry(32'h2000, 32'h0, 1'b1));
        do_redirect(32'h2000);
        check("t5_t1_inst_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check("t5_t2_inst_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        check("t5_t3_inst_valid", {63'b0, inst_valid}, 64'd1);
        check("t5_t3_miss", {63'b0, inst_tlb_miss}, 64'd1);
        wait_exp_empty("t5_marker2");

        // Redirect to 0 resumes fetch; request two cycles after the redirect.
        miss_en = 1'b0;
        exp_addr_q.push_back(20'h0);
        push_words(32'h0);
        grants += 1;
        do_redirect(32'h0);
        check("t5_r1_req_valid", {63'b0, req_valid}, 64'd0);
        tick();
        check("t5_r2_req_valid", {63'b0, req_valid}, 64'd1);
        check("t5_r2_req_addr", {44'b0, req_addr}, 64'h0);
        wait_exp_empty("t5_resume");
        wait_req("t5_next_req");

        // Reset during REQ, then a stray response that must be ignored.
        reset = 1'b0;
        #1;
        check("t6_rst_tlb_va", {32'b0, tlb_va}, 64'h0);
        check("t6_rst_req_valid", {63'b0, req_valid}, 64'd0);
        check("t6_rst_req_addr", {44'b0, req_addr}, 64'd0);
        check("t6_rst_inst_valid", {63'b0, inst_valid}, 64'd0);
        tick();
        reset     = 1'b1;
        stray_req = 1'b1;
        repeat (8) tick();
        check("t6_stray_no_inst", {63'b0, inst_valid}, 64'd0);
        check("t6_req_valid", {63'b0, req_valid}, 64'd1);
        check("t6_req_addr", {44'b0, req_addr}, 64'h0);

        check("exp_inst_left", 64'(exp_q.size()), 64'd0);
        check("exp_addr_left", 64'(exp_addr_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
